// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode stage.
// The master side is the fetch unit. The slave side is the memory and decode environment.
interface instruction_fetch_unit_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic        align_error;
  logic [31:0] instr_count;

  modport master (
    output imem_ren, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
           out_opcode, out_funct, out_rs, out_rt, out_rd, align_error, instr_count,
    input  imem_dout, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_ren, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
           out_opcode, out_funct, out_rs, out_rt, out_rd, align_error, instr_count,
    output imem_dout, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory with a fixed latency and
// presents the captured word with pre-split fields over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic                        clock,
  input logic                        reset,
  instruction_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        ren_q, ren_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] opc4_q, opc4_d;
  logic        align_q, align_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] target;

  assign target = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ren_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      opc4_q  <= '0;
      align_q <= 1'b0;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
      align_q <= align_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ren_d   = ren_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    opc4_d  = opc4_q;
    align_d = align_q;
    count_d = count_q;
    wait_d  = wait_q;

    if (bus.redirect_valid) begin
      // A handshake on the redirect edge still counts, but the target replaces pc+4.
      if (state_q == HOLD && bus.out_ready) count_d = count_q + 32'd1;
      if (bus.redirect_pc[1:0] != 2'b00) align_d = 1'b1;
      pc_d    = target;
      addr_d  = target;
      wait_d  = '0;
      valid_d = 1'b0;
      ren_d   = 1'b1;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          ren_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
        FETCH: begin
          if (wait_q == LAST_WAIT) begin
            instr_d = bus.imem_dout;
            opc_d   = pc_q;
            opc4_d  = pc_q + 32'd4;
            valid_d = 1'b1;
            ren_d   = 1'b0;
            wait_d  = '0;
            state_d = HOLD;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            count_d = count_q + 32'd1;
            valid_d = 1'b0;
            pc_d    = pc_q + 32'd4;
            addr_d  = pc_q + 32'd4;
            ren_d   = 1'b1;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.imem_ren     = ren_q;
  assign bus.imem_addr    = addr_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_instr    = instr_q;
  assign bus.out_pc       = opc_q;
  assign bus.out_pc_plus4 = opc4_q;
  assign bus.out_opcode   = instr_q[31:26];
  assign bus.out_funct    = instr_q[5:0];
  assign bus.out_rs       = instr_q[25:21];
  assign bus.out_rt       = instr_q[20:16];
  assign bus.out_rd       = instr_q[15:11];
  assign bus.align_error  = align_q;
  assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of instruction_fetch_unit against a transaction-level
// model of the expected instruction stream, handshake count and latency.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_unit_if if1 ();
  instruction_fetch_unit_if if3 ();
  instruction_fetch_unit_if ifw ();

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0) return 32'h0230_8020;
    if (a == 32'h4) return 32'h0230_8022;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign if1.imem_dout = memval(if1.imem_addr);
  assign if3.imem_dout = memval(if3.imem_addr);
  assign ifw.imem_dout = memval(ifw.imem_addr);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1)) u1 (
    .clock(clk), .reset(rst_n), .bus(if1));
  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(3)) u3 (
    .clock(clk), .reset(rst_n), .bus(if3));
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MEM_LATENCY(1)) uw (
    .clock(clk), .reset(rst_n), .bus(ifw));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model state for the randomized phase, index 0 = latency 1, 1 = latency 3.
  logic [31:0] m_pc [2];
  logic [31:0] m_cnt [2];
  logic        m_al [2];
  logic        m_prev_v [2];
  logic        m_started [2];
  int          m_gap [2];
  int          m_lat [2] = '{1, 3};
  logic        d_rdy [2];
  logic        d_red [2];
  logic [31:0] d_rpc [2];

  task automatic model_step(input int d, input logic valid, input logic ren,
                            input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] opc, input logic [31:0] opc4,
                            input logic [5:0] opcode, input logic [5:0] funct,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic align, input logic [31:0] cnt);
    logic hs;
    hs = m_prev_v[d] && d_rdy[d];
    if (hs) m_cnt[d] = m_cnt[d] + 1;
    if (d_red[d]) begin
      m_pc[d] = d_rpc[d] & 32'hFFFF_FFFC;
      if (d_rpc[d] % 4 != 0) m_al[d] = 1'b1;
    end else if (hs) begin
      m_pc[d] = m_pc[d] + 4;
    end
    if (d_red[d] || hs) begin
      m_gap[d] = 0;
      m_started[d] = 1'b1;
    end
    if (!valid) m_gap[d]++;
    check("rnd_count", cnt, m_cnt[d]);
    check("rnd_align", 32'(align), 32'(m_al[d]));
    if (valid && !m_prev_v[d] && m_started[d]) check("rnd_latency", 32'(m_gap[d]), 32'(m_lat[d]));
    if (m_started[d]) begin
      check("rnd_ren", 32'(ren), 32'(!valid));
      check("rnd_addr", addr, m_pc[d]);
    end
    if (valid) begin
      check("rnd_out_pc", opc, m_pc[d]);
      check("rnd_instr", instr, memval(m_pc[d]));
      check("rnd_pc_plus4", opc4, m_pc[d] + 4);
      check("rnd_opcode", 32'(opcode), instr >> 26);
      check("rnd_funct", 32'(funct), instr % 64);
      check("rnd_rs", 32'(rs), (instr >> 21) % 32);
      check("rnd_rt", 32'(rt), (instr >> 16) % 32);
      check("rnd_rd", 32'(rd), (instr >> 11) % 32);
    end
    m_prev_v[d] = valid;
  endtask

  initial begin
    if1.out_ready = 1'b0; if1.redirect_valid = 1'b0; if1.redirect_pc = '0;
    if3.out_ready = 1'b0; if3.redirect_valid = 1'b0; if3.redirect_pc = '0;
    ifw.out_ready = 1'b0; ifw.redirect_valid = 1'b0; ifw.redirect_pc = '0;
    rst_n = 1'b0;
    #12;
    check("rst_ren", 32'(if1.imem_ren), 32'd0);
    check("rst_addr", if1.imem_addr, 32'h0);
    check("rst_valid", 32'(if1.out_valid), 32'd0);
    check("rst_instr", if1.out_instr, 32'h0);
    check("rst_pc_plus4", if1.out_pc_plus4, 32'h0);
    check("rst_count", if1.instr_count, 32'h0);
    check("rst_align", 32'(if1.align_error), 32'd0);
    check("rst_addr_w", ifw.imem_addr, 32'hFFFF_FFFC);

    // First fetch and backpressure, latency 1.
    @(negedge clk); rst_n = 1'b1; if1.out_ready = 1'b1;
    @(negedge clk);
    check("f1_ren", 32'(if1.imem_ren), 32'd1);
    check("f1_valid_early", 32'(if1.out_valid), 32'd0);
    @(negedge clk);
    check("f1_valid", 32'(if1.out_valid), 32'd1);
    check("f1_instr", if1.out_instr, 32'h0230_8020);
    check("f1_opcode", 32'(if1.out_opcode), 32'd0);
    check("f1_funct", 32'(if1.out_funct), 32'd32);
    check("f1_rs", 32'(if1.out_rs), 32'd17);
    check("f1_rt", 32'(if1.out_rt), 32'd16);
    check("f1_rd", 32'(if1.out_rd), 32'd16);
    check("f1_pc", if1.out_pc, 32'h0);
    check("f1_pc_plus4", if1.out_pc_plus4, 32'h4);
    @(negedge clk);
    check("f1_count", if1.instr_count, 32'd1);
    check("f1_next_addr", if1.imem_addr, 32'h4);
    @(negedge clk);
    check("f2_pc", if1.out_pc, 32'h4);
    check("f2_funct", 32'(if1.out_funct), 32'd34);
    if1.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_instr", if1.out_instr, 32'h0230_8022);
      check("bp_pc", if1.out_pc, 32'h4);
      check("bp_ren", 32'(if1.imem_ren), 32'd0);
      check("bp_count", if1.instr_count, 32'd1);
    end
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    check("bp_count2", if1.instr_count, 32'd2);
    check("bp_addr", if1.imem_addr, 32'h8);
    check("bp_valid", 32'(if1.out_valid), 32'd0);

    // PC wrap on the RESET_PC=FFFF_FFFC instance, held since reset release.
    check("wrap_pc", ifw.out_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", ifw.out_pc_plus4, 32'h0);
    ifw.out_ready = 1'b1;
    @(negedge clk);
    ifw.out_ready = 1'b0;
    check("wrap_addr", ifw.imem_addr, 32'h0);
    check("wrap_count", ifw.instr_count, 32'd1);

    // Asynchronous reset between edges while holding.
    check("ar_hold_valid", 32'(if1.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(if1.out_valid), 32'd0);
    check("ar_ren", 32'(if1.imem_ren), 32'd0);
    check("ar_addr", if1.imem_addr, 32'h0);
    check("ar_count", if1.instr_count, 32'd0);
    check("ar_addr_w", ifw.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ar_restart_ren", 32'(if1.imem_ren), 32'd1);
    @(negedge clk);
    check("ar_restart_pc", if1.out_pc, 32'h0);
    check("ar_restart_valid", 32'(if1.out_valid), 32'd1);

    // Latency 3: ren high exactly 3 cycles, valid every 4 cycles.
    @(negedge clk); rst_n = 1'b0; if3.out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("l3_valid", 32'(if3.out_valid), 32'((k >= 4) && ((k - 4) % 4 == 0)));
      check("l3_ren", 32'(if3.imem_ren), 32'(!((k >= 4) && ((k - 4) % 4 == 0))));
    end
    check("l3_count", if3.instr_count, 32'd4);
    if3.out_ready = 1'b0;

    // Redirect on the second fetch cycle, misaligned redirect, redirect with handshake.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; if3.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if3.redirect_valid = 1'b1; if3.redirect_pc = 32'h40;
    @(negedge clk);
    if3.redirect_valid = 1'b0;
    check("rd_addr", if3.imem_addr, 32'h40);
    check("rd_valid0", 32'(if3.out_valid), 32'd0);
    check("rd_align0", 32'(if3.align_error), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rd_no_old", 32'(if3.out_valid), 32'd0);
    end
    @(negedge clk);
    check("rd_valid", 32'(if3.out_valid), 32'd1);
    check("rd_pc", if3.out_pc, 32'h40);
    check("rd_instr", if3.out_instr, memval(32'h40));
    if3.out_ready = 1'b0; if3.redirect_valid = 1'b1; if3.redirect_pc = 32'h43;
    @(negedge clk);
    if3.redirect_valid = 1'b0;
    check("mis_addr", if3.imem_addr, 32'h40);
    check("mis_align", 32'(if3.align_error), 32'd1);
    check("mis_valid", 32'(if3.out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("hsr_valid", 32'(if3.out_valid), 32'd1);
    check("hsr_count0", if3.instr_count, 32'd0);
    if3.out_ready = 1'b1; if3.redirect_valid = 1'b1; if3.redirect_pc = 32'h100;
    @(negedge clk);
    if3.out_ready = 1'b0; if3.redirect_valid = 1'b0;
    check("hsr_count", if3.instr_count, 32'd1);
    check("hsr_addr", if3.imem_addr, 32'h100);
    check("hsr_valid0", 32'(if3.out_valid), 32'd0);
    check("hsr_align", 32'(if3.align_error), 32'd1);

    // Randomized ready/redirect traffic on both latency configurations.
    @(negedge clk); rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = '0; m_cnt[d] = '0; m_al[d] = 1'b0; m_prev_v[d] = 1'b0;
      m_started[d] = 1'b0; m_gap[d] = 0;
      d_rdy[d] = 1'b0; d_red[d] = 1'b0; d_rpc[d] = '0;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      model_step(0, if1.out_valid, if1.imem_ren, if1.imem_addr, if1.out_instr, if1.out_pc,
                 if1.out_pc_plus4, if1.out_opcode, if1.out_funct, if1.out_rs, if1.out_rt,
                 if1.out_rd, if1.align_error, if1.instr_count);
      model_step(1, if3.out_valid, if3.imem_ren, if3.imem_addr, if3.out_instr, if3.out_pc,
                 if3.out_pc_plus4, if3.out_opcode, if3.out_funct, if3.out_rs, if3.out_rt,
                 if3.out_rd, if3.align_error, if3.instr_count);
      for (int d = 0; d < 2; d++) begin
        d_rdy[d] = 1'($urandom_range(0, 1));
        d_red[d] = ($urandom_range(0, 11) == 0);
        d_rpc[d] = $urandom;
      end
      if1.out_ready = d_rdy[0]; if1.redirect_valid = d_red[0]; if1.redirect_pc = d_rpc[0];
      if3.out_ready = d_rdy[1]; if3.redirect_valid = d_red[1]; if3.redirect_pc = d_rpc[1];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
